// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default data-memory depth.
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 64;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    // Alignment rule: halves need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF && addr_lo[0])
            bad = 1'b1;
        if (size == SZ_WORD && addr_lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: load extract/extend and the
// read-modify-write merge used by sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
        ld_byte   = rdata[{addr_lo, 3'b000} +: 8];
        ld_half   = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h0, ld_byte}
                                             : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = is_unsigned ? {16'h0, ld_half}
                                             : {{16{ld_half[15]}}, ld_half};
            default: load_data = rdata;
        endcase
    end

    // Untouched lanes keep the word just read, since the memory has no byte enables.
    always_comb begin
        merged = rdata;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one outstanding byte/half/word access, read-modify-write
// for sub-word stores, valid/ready response with error reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        unsigned_q, unsigned_d;
    logic        error_q, error_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    lsu_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_comb begin
        req_err = 1'b0;
        if (req_size == SZ_ILLEGAL)
            req_err = 1'b1;
        if (is_misaligned(req_size, req_addr[1:0]))
            req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS)
            req_err = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        error_d    = error_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    error_d    = req_err;
                    rdata_d    = 32'h0;
                    if (req_err)
                        state_d = RESP;
                    else if (req_write && req_size == SZ_WORD)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                // wdata_q is reused to hold the merged word for the following WR.
                if (write_q) begin
                    wdata_d = merged;
                    state_d = WR;
                end else begin
                    rdata_d = load_data;
                    state_d = RESP;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            size_q     <= SZ_BYTE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            error_q    <= 1'b0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            error_q    <= error_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs decode from the state register alone, so reset drops them without a clock.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
        rsp_error = (state_q == RESP) && error_q;
        mem_read  = (state_q == RD);
        mem_write = (state_q == WR);
        mem_addr  = (state_q == RD || state_q == WR) ? {2'b00, addr_q[31:2]} : 32'h0;
        mem_wdata = (state_q == WR) ? wdata_q : 32'h0;
    end

    strobes_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_read && mem_write));

endmodule
